// File: rtl/flash_playback_ctrl.sv
// Flash-backed audio playback: fetches 32-bit words over Avalon-MM and emits
// two 16-bit samples per word, in either playback direction.
module flash_playback_ctrl #(
  parameter int                ADDR_W   = 23,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              cmd_play,
  input  logic              cmd_pause,
  input  logic              cmd_restart,
  input  logic              cmd_fwd,
  input  logic              cmd_bwd,
  output logic [ADDR_W-1:0] flsh_address,
  output logic              flsh_read,
  input  logic              flsh_waitrequest,
  input  logic [31:0]       flsh_readdata,
  input  logic              flsh_readdatavalid,
  output logic [3:0]        flsh_byteenable,
  output logic [15:0]       audio_out,
  output logic              audio_valid,
  output logic              playing,
  output logic              forward,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, EMIT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              half;
  logic              restart_pend;
  logic [31:0]       word_buf;
  logic              tick_go;
  logic              use_high;

  function automatic logic [ADDR_W-1:0] wrap_step(input logic [ADDR_W-1:0] a,
                                                  input logic fwd);
    if (fwd)
      return (a == MAX_ADDR) ? '0 : a + ADDR_W'(1);
    else
      return (a == '0) ? MAX_ADDR : a - ADDR_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] restart_addr(input logic fwd);
    return fwd ? '0 : MAX_ADDR;
  endfunction

  assign tick_go  = sample_tick && playing && (state == IDLE);
  // Backward playback reverses the order of the two halves within a word.
  assign use_high = half ^ ~forward;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (tick_go) state_nxt = (half && !cmd_restart) ? EMIT : REQ;
      REQ:       if (!flsh_waitrequest) state_nxt = WAIT_DATA;
      WAIT_DATA: if (flsh_readdatavalid) state_nxt = EMIT;
      EMIT:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    flsh_read       = (state == REQ);
    flsh_address    = addr;
    flsh_byteenable = 4'b1111;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr         <= '0;
      half         <= 1'b0;
      restart_pend <= 1'b0;
      word_buf     <= '0;
      audio_out    <= '0;
      audio_valid  <= 1'b0;
      playing      <= 1'b0;
      forward      <= 1'b1;
      overrun      <= 1'b0;
    end else begin
      audio_valid <= (state == EMIT);

      // Restart outranks pause, which outranks play.
      if (cmd_pause && !cmd_restart)     playing <= 1'b0;
      else if (cmd_play && !cmd_restart) playing <= 1'b1;

      if (cmd_fwd && !cmd_bwd)      forward <= 1'b1;
      else if (cmd_bwd && !cmd_fwd) forward <= 1'b0;

      if (sample_tick && playing && (state != IDLE)) overrun <= 1'b1;

      if ((state == WAIT_DATA) && flsh_readdatavalid) word_buf <= flsh_readdata;

      if (state == EMIT) begin
        audio_out <= use_high ? word_buf[31:16] : word_buf[15:0];
        if (cmd_restart || restart_pend) begin
          addr         <= restart_addr(forward);
          half         <= 1'b0;
          restart_pend <= 1'b0;
        end else begin
          half <= ~half;
          if (half) addr <= wrap_step(addr, forward);
        end
      end else if (cmd_restart) begin
        // A restart mid-fetch waits for the sample to emit before it lands.
        if (state == IDLE) begin
          addr <= restart_addr(forward);
          half <= 1'b0;
        end else begin
          restart_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_flash_playback_ctrl.sv
// Bench for flash_playback_ctrl: directed scenarios plus randomized traffic
// scored cycle by cycle against an event-level playback model.
module tb_flash_playback_ctrl;

  localparam int                ADDR_W   = 23;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_tick = 0, cmd_play = 0, cmd_pause = 0, cmd_restart = 0;
  logic              cmd_fwd = 0, cmd_bwd = 0;
  logic [ADDR_W-1:0] flsh_address;
  logic              flsh_read;
  logic              flsh_waitrequest = 0;
  logic [31:0]       flsh_readdata = 0;
  logic              flsh_readdatavalid = 0;
  logic [3:0]        flsh_byteenable;
  logic [15:0]       audio_out;
  logic              audio_valid, playing, forward, overrun;

  always #5 clk = ~clk;

  flash_playback_ctrl #(.ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .cmd_play(cmd_play), .cmd_pause(cmd_pause), .cmd_restart(cmd_restart),
    .cmd_fwd(cmd_fwd), .cmd_bwd(cmd_bwd),
    .flsh_address(flsh_address), .flsh_read(flsh_read),
    .flsh_waitrequest(flsh_waitrequest), .flsh_readdata(flsh_readdata),
    .flsh_readdatavalid(flsh_readdatavalid), .flsh_byteenable(flsh_byteenable),
    .audio_out(audio_out), .audio_valid(audio_valid),
    .playing(playing), .forward(forward), .overrun(overrun)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Flash contents: word 0 is BBBB_AAAA, every other word has distinct halves.
  function automatic logic [31:0] memw(input logic [ADDR_W-1:0] a);
    return {a[15:0] ^ 16'hBBBB, a[15:0] ^ 16'hAAAA};
  endfunction

  // Slave knobs and state
  int                p_wait = 0, rdv_min = 1, rdv_max = 1;
  int                rdv_cnt = 0;
  logic [ADDR_W-1:0] rdv_addr = '0;

  // Reference model
  logic              m_playing, m_forward, m_overrun, m_busy, m_emit_due;
  logic              m_req, m_wait, m_pend, m_half, m_valid;
  logic [ADDR_W-1:0] m_addr, m_req_addr;
  logic [31:0]       m_word;
  logic [15:0]       m_audio;

  int                read_cnt = 0, lat = 0;
  logic [ADDR_W-1:0] last_read_addr = '0;

  task automatic model_reset();
    m_playing = 0; m_forward = 1; m_overrun = 0; m_busy = 0; m_emit_due = 0;
    m_req = 0; m_wait = 0; m_pend = 0; m_half = 0; m_valid = 0;
    m_addr = '0; m_req_addr = '0; m_word = '0; m_audio = '0; rdv_cnt = 0;
  endtask

  task automatic model_edge(input logic [ADDR_W-1:0] adr_s);
    logic              emit_now, fwd_old, accept;
    logic [ADDR_W-1:0] raddr;
    emit_now = m_emit_due;
    fwd_old  = m_forward;
    raddr    = fwd_old ? '0 : MAX_ADDR;
    m_valid  = emit_now;
    if (sample_tick && m_playing && m_busy) m_overrun = 1;
    accept = sample_tick && m_playing && !m_busy;
    if (emit_now) begin
      m_audio = (m_half ^ !fwd_old) ? m_word[31:16] : m_word[15:0];
      if (m_pend || cmd_restart) begin
        m_addr = raddr; m_half = 0; m_pend = 0;
      end else begin
        if (m_half)
          m_addr = fwd_old ? ADDR_W'((int'(m_addr) + 1) % (int'(MAX_ADDR) + 1))
                           : ADDR_W'((int'(m_addr) + int'(MAX_ADDR)) % (int'(MAX_ADDR) + 1));
        m_half = !m_half;
      end
      m_busy = 0; m_emit_due = 0;
    end else if (cmd_restart) begin
      if (m_busy) m_pend = 1;
      else begin m_addr = raddr; m_half = 0; end
    end
    if (m_wait && flsh_readdatavalid) begin
      m_word = memw(m_req_addr); m_wait = 0; m_emit_due = 1;
    end
    if (rdv_cnt > 0) rdv_cnt--;
    if (m_req && !flsh_waitrequest) begin
      m_req = 0; m_wait = 1;
      rdv_cnt = $urandom_range(rdv_max, rdv_min);
      rdv_addr = adr_s;
    end
    if (accept) begin
      m_busy = 1;
      if (m_half) m_emit_due = 1;
      else begin m_req = 1; m_req_addr = m_addr; end
    end
    if (!cmd_restart) begin
      if (cmd_pause) m_playing = 0;
      else if (cmd_play) m_playing = 1;
    end
    if (cmd_fwd && !cmd_bwd) m_forward = 1;
    else if (cmd_bwd && !cmd_fwd) m_forward = 0;
  endtask

  task automatic check_outputs();
    chk("audio_out", audio_out, m_audio);
    chk("audio_valid", audio_valid, m_valid);
    chk("flsh_read", flsh_read, m_req);
    if (m_req) chk("flsh_address", flsh_address, m_req_addr);
    chk("playing", playing, m_playing);
    chk("forward", forward, m_forward);
    chk("overrun", overrun, m_overrun);
    chk("byteenable", flsh_byteenable, 4'hF);
    if (flsh_read) begin
      read_cnt++;
      last_read_addr = flsh_address;
    end
  endtask

  // One clock: called at a negedge with this cycle's command/tick inputs set.
  task automatic cyc();
    logic [ADDR_W-1:0] adr_s;
    adr_s = flsh_address;
    flsh_waitrequest = ($urandom_range(99, 0) < p_wait);
    if (rdv_cnt == 1) begin
      flsh_readdatavalid = 1; flsh_readdata = memw(rdv_addr);
    end else begin
      flsh_readdatavalid = 0; flsh_readdata = $urandom;
    end
    @(posedge clk);
    model_edge(adr_s);
    @(negedge clk);
    sample_tick = 0; cmd_play = 0; cmd_pause = 0; cmd_restart = 0;
    cmd_fwd = 0; cmd_bwd = 0;
    check_outputs();
  endtask

  task automatic tick_wait(input string tag, input logic do_tick);
    sample_tick = do_tick;
    read_cnt = 0;
    cyc();
    lat = 1;
    while (!audio_valid && lat < 60) begin cyc(); lat++; end
    if (!audio_valid) chk({tag, "_timeout"}, 0, 1);
  endtask

  logic [31:0] w;
  int          r, n;

  initial begin
    #2 rst = 0;
    #1;
    chk("rst_read", flsh_read, 0);
    chk("rst_audio", audio_out, 0);
    chk("rst_valid", audio_valid, 0);
    chk("rst_playing", playing, 0);
    chk("rst_forward", forward, 1);
    chk("rst_overrun", overrun, 0);
    chk("rst_addr", flsh_address, 0);
    model_reset();
    @(negedge clk);
    rst = 1;

    // Basic play: low half, high half without a fetch, then next word.
    cmd_play = 1; cyc();
    tick_wait("t1", 1);
    chk("r040_aaaa", audio_out, 16'hAAAA);
    chk("r040_addr0", last_read_addr, 0);
    chk("lat_half0", lat, 4);
    tick_wait("t2", 1);
    chk("r040_bbbb", audio_out, 16'hBBBB);
    chk("r040_noread", read_cnt, 0);
    chk("lat_half1", lat, 2);
    tick_wait("t3", 1);
    w = memw(1);
    chk("r040_addr1", last_read_addr, 1);
    chk("r040_w1lo", audio_out, w[15:0]);

    // Stalled read: six stable request cycles, overrun on a dropped tick.
    cmd_restart = 1; cyc();
    p_wait = 100; sample_tick = 1; read_cnt = 0; cyc();
    for (int i = 0; i < 5; i++) begin
      sample_tick = (i == 2);
      cyc();
    end
    p_wait = 0; cyc();
    chk("r041_readcycles", read_cnt, 6);
    chk("r041_overrun", overrun, 1);
    tick_wait("t041", 0);
    chk("r041_sample", audio_out, 16'hAAAA);

    // Forward wrap MAX_ADDR -> 0.
    cmd_bwd = 1; cyc();
    cmd_restart = 1; cyc();
    cmd_fwd = 1; cyc();
    tick_wait("wf1", 1);
    w = memw(MAX_ADDR);
    chk("r042_readmax", last_read_addr, MAX_ADDR);
    chk("r042_maxlo", audio_out, w[15:0]);
    tick_wait("wf2", 1);
    tick_wait("wf3", 1);
    chk("r042_wrap0", last_read_addr, 0);

    // Backward wrap 0 -> MAX_ADDR, high half first.
    cmd_restart = 1; cyc();
    cmd_bwd = 1; cyc();
    tick_wait("wb1", 1);
    chk("r042_bread0", last_read_addr, 0);
    chk("r042_bhigh", audio_out, 16'hBBBB);
    tick_wait("wb2", 1);
    chk("r042_blow", audio_out, 16'hAAAA);
    tick_wait("wb3", 1);
    chk("r042_wrapmax", last_read_addr, MAX_ADDR);
    chk("r042_maxhi", audio_out, w[31:16]);

    // Restart held pending during a slow read at address 5.
    cmd_fwd = 1; cyc();
    cmd_restart = 1; cyc();
    for (int i = 0; i < 10; i++) tick_wait("walk", 1);
    rdv_min = 4; rdv_max = 4;
    sample_tick = 1; cyc();
    n = 0;
    while (!m_wait && n < 20) begin cyc(); n++; end
    chk("r043_inwait", m_wait, 1);
    cmd_restart = 1;
    tick_wait("t043", 0);
    w = memw(5);
    chk("r043_addr5", last_read_addr, 5);
    chk("r043_sample5", audio_out, w[15:0]);
    rdv_min = 1; rdv_max = 1;
    tick_wait("t043b", 1);
    chk("r043_restart0", last_read_addr, 0);

    // Reset mid-request, then a late readdatavalid and ticks while stopped.
    cmd_restart = 1; cyc();
    p_wait = 100; sample_tick = 1; cyc();
    chk("r044_read_pre", flsh_read, 1);
    rst = 0;
    #1;
    chk("r044_read", flsh_read, 0);
    chk("r044_audio", audio_out, 0);
    chk("r044_valid", audio_valid, 0);
    chk("r044_playing", playing, 0);
    chk("r044_forward", forward, 1);
    chk("r044_overrun", overrun, 0);
    chk("r044_addr", flsh_address, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    p_wait = 0; rdv_cnt = 1; rdv_addr = 5; read_cnt = 0;
    cyc();
    for (int i = 0; i < 5; i++) begin sample_tick = 1; cyc(); end
    chk("r044_noread", read_cnt, 0);

    // Randomized traffic.
    p_wait = 30; rdv_min = 1; rdv_max = 3;
    cmd_play = 1; cyc();
    for (int i = 0; i < 2500; i++) begin
      sample_tick = ($urandom_range(99, 0) < 35);
      r = $urandom_range(99, 0);
      if (r < 4) cmd_play = 1;
      else if (r < 6) cmd_pause = 1;
      else if (r < 8) begin cmd_play = 1; cmd_pause = 1; end
      else if (r < 10) cmd_restart = 1;
      else if (r < 12) cmd_fwd = 1;
      else if (r < 14) cmd_bwd = 1;
      else if (r < 15) begin cmd_fwd = 1; cmd_bwd = 1; end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
